// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 slave with byte register file (optional IRQ: SPI_SLAVE_IRQ_EN)
module spi_slave_regfile #(
    parameter int NREGS = 16
) (
    input  logic               sys_clk,
    input  logic               sys_nreset,
    input  logic               spi_s_sclk,
    input  logic               spi_s_mosi,
    input  logic               spi_s_ss,
    output logic               spi_s_miso,
    input  logic               reg_wr_en,
    input  logic [5:0]         reg_wr_addr,
    input  logic [7:0]         reg_wr_data,
    output logic               access_valid,
    output logic               access_write,
    output logic [5:0]         access_addr,
    output logic [7:0]         access_data,
    output logic [NREGS*8-1:0] regs_out,
    output logic               spi_irq,
    input  logic               irq_clear
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t      state_q, state_d;
    logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic        mosi_s1_q, mosi_s2_q, ss_s1_q, ss_s2_q;
    logic        rise_q, fall_q, mosi_q;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  rx_q, rx_d, tx_q, tx_d, txbyte_q, txbyte_d;
    logic        rw_q, rw_d, inc_q, inc_d;
    logic [5:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic        acc_valid_q, acc_valid_d, acc_write_q, acc_write_d;
    logic [5:0]  acc_addr_q, acc_addr_d;
    logic [7:0]  acc_data_q, acc_data_d;
    logic        spi_we;
    logic [7:0]  rx_byte;
    logic [7:0]  regs_q [NREGS];

    // Unimplemented addresses read as zero.
    function automatic logic [7:0] rd_reg(input logic [5:0] a);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (a == 6'(i)) v = regs_q[i];
        end
        return v;
    endfunction

    // The edge pulses and mosi are registered together so they stay aligned.
    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0;
            ss_s1_q   <= 1'b1; ss_s2_q   <= 1'b1;
            rise_q    <= 1'b0; fall_q    <= 1'b0; mosi_q <= 1'b0;
        end else begin
            sclk_s1_q <= spi_s_sclk; sclk_s2_q <= sclk_s1_q; sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= spi_s_mosi; mosi_s2_q <= mosi_s1_q;
            ss_s1_q   <= spi_s_ss;   ss_s2_q   <= ss_s1_q;
            rise_q    <= sclk_s2_q & ~sclk_s3_q;
            fall_q    <= ~sclk_s2_q & sclk_s3_q;
            mosi_q    <= mosi_s2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            txbyte_q    <= 8'h00;
            rw_q        <= 1'b0;
            inc_q       <= 1'b0;
            addr_q      <= 6'd0;
            miso_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_write_q <= 1'b0;
            acc_addr_q  <= 6'd0;
            acc_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            txbyte_q    <= txbyte_d;
            rw_q        <= rw_d;
            inc_q       <= inc_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            acc_valid_q <= acc_valid_d;
            acc_write_q <= acc_write_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        txbyte_d    = txbyte_q;
        rw_d        = rw_q;
        inc_d       = inc_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        acc_valid_d = 1'b0;
        acc_write_d = acc_write_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        spi_we      = 1'b0;
        rx_byte     = {rx_q[6:0], mosi_q};
        if (ss_s2_q) begin
            state_d = IDLE;
            miso_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d  = CMD;
            bitcnt_d = 3'd0;
            tx_d     = 8'h00;
            miso_d   = 1'b0;
        end else begin
            if (fall_q) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
            if (rise_q) begin
                rx_d     = rx_byte;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    if (state_q == CMD) begin
                        rw_d    = rx_byte[7];
                        inc_d   = rx_byte[6];
                        addr_d  = rx_byte[5:0];
                        state_d = DATA;
                        if (rx_byte[7]) begin
                            txbyte_d = rd_reg(rx_byte[5:0]);
                            tx_d     = txbyte_d;
                        end
                    end else begin
                        acc_valid_d = 1'b1;
                        acc_write_d = ~rw_q;
                        acc_addr_d  = addr_q;
                        addr_d      = addr_q + {5'd0, inc_q};
                        if (rw_q) begin
                            acc_data_d = txbyte_q;
                            txbyte_d   = rd_reg(addr_q + {5'd0, inc_q});
                            tx_d       = txbyte_d;
                        end else begin
                            acc_data_d = rx_byte;
                            spi_we     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // SPI write is checked first so it wins a same-address collision.
    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (spi_we && addr_q == 6'(i)) regs_q[i] <= rx_byte;
                else if (reg_wr_en && reg_wr_addr == 6'(i)) regs_q[i] <= reg_wr_data;
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs_out[8*g +: 8] = regs_q[g];
    end

    assign spi_s_miso   = miso_q;
    assign access_valid = acc_valid_q;
    assign access_write = acc_write_q;
    assign access_addr  = acc_addr_q;
    assign access_data  = acc_data_q;

`ifdef SPI_SLAVE_IRQ_EN
    logic flag_q, irq_q;

    // Leaving a non-IDLE state on synced ss high is exactly the ss rising edge.
    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            flag_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && !ss_s2_q) flag_q <= 1'b0;
            else if (spi_we)                 flag_q <= 1'b1;
            if (state_q != IDLE && ss_s2_q && flag_q) irq_q <= 1'b1;
            else if (irq_clear)                       irq_q <= 1'b0;
        end
    end
    assign spi_irq = irq_q;
`else
    logic unused_irq_clear;
    assign unused_irq_clear = irq_clear;
    assign spi_irq          = 1'b0;
`endif
endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI slave back end wired to the spi_s_* pins of the Parallella SPI top: spi_s_sclk, spi_s_mosi and spi_s_ss in, spi_s_miso out.
- Oversamples the SPI pins in the sys_clk domain and decodes command/data frames.
- Holds a small byte-wide register file that an external SPI master can write and read back.
- Emits a one-cycle access strobe per completed data byte. A fabric-side write port updates registers (e.g. status) for the master to read.

Parameters:
NREGS, 16, number of 8-bit registers implemented (1..64); addresses >= NREGS are unimplemented

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_nreset  in  1  asynchronous active-low reset
spi_s_sclk  in  1  SPI clock from pins, asynchronous, mode 0 (CPOL=0, CPHA=0)
spi_s_mosi  in  1  SPI data in, MSB first
spi_s_ss  in  1  SPI slave select, active low
spi_s_miso  out  1  SPI data out, registered
reg_wr_en  in  1  fabric register write strobe
reg_wr_addr  in  6  fabric write address
reg_wr_data  in  8  fabric write data
access_valid  out  1  one-cycle pulse per completed data byte
access_write  out  1  1 = SPI write, 0 = SPI read (valid with access_valid)
access_addr  out  6  byte address of the access
access_data  out  8  byte written, or byte returned
regs_out  out  NREGS*8  flat register file contents; reg i at [8i+7:8i]
spi_irq  out  1  frame-write interrupt (see Optional Feature)
irq_clear  in  1  clears spi_irq

Behaviour:
- Reset values (asynchronous assert):
  - All registers 0x00.
  - spi_s_miso, access_valid, access_write 0; access_addr 0, access_data 0; spi_irq 0.
  - Synchronizers: sclk=0, ss=1, mosi=0.
  - State IDLE.
- Synchronization:
  - 2-flop synchronizer on sclk, mosi, ss, plus a third sclk stage for edge detect.
  - sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3. mosi is sampled from its stage-2 flop.
  - Timing requirement: sclk high and low phases each >= 4 sys_clk periods. Faster sclk is out of spec and behaviour is undefined.
- States: IDLE, CMD, DATA.
  - IDLE -> CMD on synced ss low: bitcnt=0, tx_sreg=0x00.
  - Any state -> IDLE whenever synced ss is high. A partial byte is discarded with no access and no register change. spi_s_miso drives 0 in IDLE.
- Receive:
  - On each sclk_rise, rx_sreg <= {rx_sreg[6:0], mosi} and bitcnt++ (3-bit counter, wraps).
  - A byte completes on the rise where bitcnt goes 7 -> 0.
- CMD byte complete:
  - Latch rw=bit7 (1 = read), inc=bit6, addr=bits[5:0]; go to DATA.
  - If rw=1, load tx_sreg with regs[addr], or 0x00 if addr >= NREGS.
- Transmit:
  - On each sclk_fall in CMD/DATA: spi_s_miso <= tx_sreg[7], tx_sreg <= tx_sreg<<1.
  - miso therefore reads 0 throughout the command byte.
- DATA byte complete, write (rw=0):
  - regs[addr] <= rx byte if addr < NREGS; otherwise dropped.
  - Pulse access_valid with write=1, addr, data = rx byte.
- DATA byte complete, read (rw=1):
  - Pulse access_valid with write=0, addr, data = the byte just shifted out.
  - Reload tx_sreg with regs[addr+inc].
- After either, addr <= addr+inc, 6-bit wrap (0x3F -> 0x00).
- Access latency: access_valid asserts on the 4th sys_clk rising edge after the completing sclk rise reaches the pin (2 sync + 1 edge detect + 1 output register).
- Fabric write:
  - reg_wr_en writes reg_wr_data to regs[reg_wr_addr] next cycle. Ignored if addr >= NREGS.
  - If SPI write and fabric write hit the same address in the same cycle, the SPI write wins. Writes to different addresses both apply.
- Read data: a read returns the register value at the moment tx_sreg loads. Later changes do not affect the byte in flight.
- Reset mid-frame: immediate return to reset values; the frame is abandoned.

Optional Feature:
- Macro SPI_SLAVE_IRQ_EN.
- Defined:
  - A frame-local flag sets on any completed SPI write byte.
  - On synced ss rising with the flag set, spi_irq <= 1 (level).
  - irq_clear clears spi_irq. Simultaneous set and clear: set wins.
  - Flag clears on ss fall.
- Undefined: spi_irq tied 0, irq_clear ignored.

Test Plan:
- Write single: NREGS=16; frame 0x05 (write, no inc, addr 5), 0xA5 -> regs[5]=0xA5; one access_valid with write=1, addr=5, data=0xA5; no other register changes.
- Burst write with wrap: NREGS=64; frame 0x7E (write, inc, addr 0x3E), 0x11, 0x22, 0x33 -> regs[0x3E]=0x11, regs[0x3F]=0x22, regs[0x00]=0x33; 3 pulses with addr 0x3E, 0x3F, 0x00.
- Burst read: preload regs[2]=0x3C, regs[3]=0xC3 via fabric port; frame 0xC2, two dummy bytes -> master samples 0x00, 0x3C, 0xC3 on miso; 2 pulses with write=0.
- Out of range: NREGS=16; write 0x14, 0x99 then read 0x94 -> no register changes; read returns 0x00; pulses still issued.
- Abort/collision: ss high after 5 bits of a data byte -> no access, state IDLE, next frame decodes normally. Same-cycle SPI and fabric write to addr 1 -> SPI byte retained.
- IRQ (with SPI_SLAVE_IRQ_EN): write frame ends -> spi_irq=1; irq_clear -> 0; read-only frame -> stays 0; without macro, always 0.
